// File: rtl/xif_copro_pkg.sv
// Shared types and constants for the coprocessor memory interface.
// Holds the ID width, the responder FSM states and the exception codes.
package xif_copro_pkg;

  localparam int unsigned X_ID_WIDTH = 4;

  localparam logic [5:0] EXC_LOAD_FAULT  = 6'd5;
  localparam logic [5:0] EXC_STORE_FAULT = 6'd7;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } xif_mem_state_e;

  function automatic logic [5:0] be_fault_code(input logic we);
    return we ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
  endfunction

endpackage

// File: rtl/xif_mem_id_fifo.sv
// Small FIFO holding instruction IDs of granted OBI transactions.
// Pointers wrap modulo DEPTH, so any depth works, not just powers of two.
module xif_mem_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the same cycle frees a slot.
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/xif_mem_responder.sv
// Bridges coprocessor memory requests onto an OBI data port and returns
// results in grant order; requests with no byte enables are rejected.
module xif_mem_responder
  import xif_copro_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [X_ID_WIDTH-1:0] mem_req_id_i,
  input  logic [31:0]           mem_req_addr_i,
  input  logic                  mem_req_we_i,
  input  logic [3:0]            mem_req_be_i,
  input  logic [31:0]           mem_req_wdata_i,
  output logic                  mem_resp_exc_o,
  output logic [5:0]            mem_resp_exccode_o,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [31:0]           data_addr_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic                  data_err_i,
  input  logic [31:0]           data_rdata_i,
  output logic                  mem_result_valid_o,
  output logic [X_ID_WIDTH-1:0] mem_result_id_o,
  output logic [31:0]           mem_result_rdata_o,
  output logic                  mem_result_err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  xif_mem_state_e        state_q, state_d;
  logic [CW-1:0]         count_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [31:0]           addr_q, wdata_q;
  logic [3:0]            be_q;
  logic                  we_q;

  logic                  can_accept, hs, be_fault, grant, resp_pop;
  logic                  fifo_full, fifo_empty;
  logic [X_ID_WIDTH-1:0] pop_id;

  logic                  res_valid_q, res_err_q;
  logic [X_ID_WIDTH-1:0] res_id_q;
  logic [31:0]           res_rdata_q;

  // Store flags ride alongside the ID FIFO so store results read back as zero.
  logic                  st_flag_q [MAX_OUTSTANDING];
  logic [PW-1:0]         st_wr_q, st_rd_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign can_accept = !rst_i && (state_q == IDLE) &&
                      (count_q < CW'(MAX_OUTSTANDING)) && !fifo_full;
  assign hs         = mem_valid_i && can_accept;
  assign be_fault   = (mem_req_be_i == '0);
  assign grant      = (state_q == REQ) && data_gnt_i;
  assign resp_pop   = data_rvalid_i && !fifo_empty;

  always_comb begin
    state_d            = state_q;
    mem_resp_exc_o     = 1'b0;
    mem_resp_exccode_o = '0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          if (be_fault) begin
            mem_resp_exc_o     = 1'b1;
            mem_resp_exccode_o = be_fault_code(mem_req_we_i);
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (data_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      st_wr_q     <= '0;
      st_rd_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs && !be_fault) begin
        id_q    <= mem_req_id_i;
        addr_q  <= mem_req_addr_i;
        wdata_q <= mem_req_wdata_i;
        be_q    <= mem_req_be_i;
        we_q    <= mem_req_we_i;
      end
      if (grant && !resp_pop)      count_q <= count_q + CW'(1);
      else if (resp_pop && !grant) count_q <= count_q - CW'(1);
      if (grant)    st_wr_q <= ptr_inc(st_wr_q);
      if (resp_pop) st_rd_q <= ptr_inc(st_rd_q);

      res_valid_q <= resp_pop;
      if (resp_pop) begin
        res_id_q    <= pop_id;
        res_rdata_q <= st_flag_q[st_rd_q] ? '0 : data_rdata_i;
        res_err_q   <= data_err_i;
      end else begin
        res_id_q    <= '0;
        res_rdata_q <= '0;
        res_err_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) st_flag_q[st_wr_q] <= we_q;
  end

  xif_mem_id_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(X_ID_WIDTH)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (grant),
    .push_data_i(id_q),
    .pop_i      (data_rvalid_i),
    .pop_data_o (pop_id),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign mem_ready_o        = can_accept;
  assign data_req_o         = !rst_i && (state_q == REQ);
  assign data_we_o          = we_q;
  assign data_addr_o        = addr_q;
  assign data_be_o          = be_q;
  assign data_wdata_o       = wdata_q;
  assign mem_result_valid_o = res_valid_q;
  assign mem_result_id_o    = res_id_q;
  assign mem_result_rdata_o = res_rdata_q;
  assign mem_result_err_o   = res_err_q;

endmodule

// File: tb/tb_xif_mem_responder.sv
// Bench for xif_mem_responder: vector table plus corner-case sequences,
// with results checked against a grant-order scoreboard.
module tb_xif_mem_responder;
  import xif_copro_pkg::*;

  localparam int unsigned MAXO = 2;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  mem_valid_i, mem_ready_o, mem_req_we_i;
  logic [X_ID_WIDTH-1:0] mem_req_id_i;
  logic [31:0]           mem_req_addr_i, mem_req_wdata_i;
  logic [3:0]            mem_req_be_i;
  logic                  mem_resp_exc_o;
  logic [5:0]            mem_resp_exccode_o;
  logic                  data_req_o, data_we_o;
  logic [31:0]           data_addr_o, data_wdata_o;
  logic [3:0]            data_be_o;
  logic                  data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0]           data_rdata_i;
  logic                  mem_result_valid_o, mem_result_err_o;
  logic [X_ID_WIDTH-1:0] mem_result_id_o;
  logic [31:0]           mem_result_rdata_o;

  always #5 clk = ~clk;

  xif_mem_responder #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_req_id_i(mem_req_id_i), .mem_req_addr_i(mem_req_addr_i),
    .mem_req_we_i(mem_req_we_i), .mem_req_be_i(mem_req_be_i),
    .mem_req_wdata_i(mem_req_wdata_i),
    .mem_resp_exc_o(mem_resp_exc_o), .mem_resp_exccode_o(mem_resp_exccode_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_rdata_i(data_rdata_i),
    .mem_result_valid_o(mem_result_valid_o), .mem_result_id_o(mem_result_id_o),
    .mem_result_rdata_o(mem_result_rdata_o), .mem_result_err_o(mem_result_err_o)
  );

  typedef struct {
    logic [X_ID_WIDTH-1:0] id;
    logic                  we;
  } grant_t;

  typedef struct {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           rdata;
    logic                  err;
  } exp_t;

  typedef struct {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    int unsigned           gnt_wait;
    logic [31:0]           rdata;
    logic                  err;
    logic                  exp_exc;
    logic [5:0]            exp_code;
  } vec_t;

  grant_t                grant_q[$];
  exp_t                  exp_q[$];
  logic [X_ID_WIDTH-1:0] cur_id;
  logic                  cur_we;
  int                    tests = 0;
  int                    fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: result monitor and OBI slave model at negedge, then step past posedge.
  task automatic cycle();
    exp_t   e;
    grant_t g;
    @(negedge clk);
    if (mem_result_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {31'd0, mem_result_valid_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result_id", {28'd0, mem_result_id_o}, {28'd0, e.id});
        check("result_rdata", mem_result_rdata_o, e.rdata);
        check("result_err", {31'd0, mem_result_err_o}, {31'd0, e.err});
      end
    end
    if (data_rvalid_i && grant_q.size() > 0) begin
      g       = grant_q.pop_front();
      e.id    = g.id;
      e.rdata = g.we ? 32'd0 : data_rdata_i;
      e.err   = data_err_i;
      exp_q.push_back(e);
    end
    if (data_gnt_i) begin
      g.id = cur_id;
      g.we = cur_we;
      grant_q.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    mem_valid_i = 1'b0; mem_req_id_i = '0; mem_req_addr_i = '0;
    mem_req_we_i = 1'b0; mem_req_be_i = '0; mem_req_wdata_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
    grant_q.delete();
    exp_q.delete();
    cycle();
    check("rst_ready", {31'd0, mem_ready_o}, 32'd0);
    check("rst_data_req", {31'd0, data_req_o}, 32'd0);
    check("rst_addr", data_addr_o, 32'd0);
    check("rst_result_valid", {31'd0, mem_result_valid_o}, 32'd0);
    cycle();
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, mem_ready_o}, 32'd1);
    check("post_rst_exc", {31'd0, mem_resp_exc_o}, 32'd0);
  endtask

  task automatic issue(input logic [X_ID_WIDTH-1:0] id, input logic [31:0] addr,
                       input logic we, input logic [3:0] be, input logic [31:0] wdata,
                       input logic exp_exc, input logic [5:0] exp_code);
    mem_valid_i = 1'b1; mem_req_id_i = id; mem_req_addr_i = addr;
    mem_req_we_i = we; mem_req_be_i = be; mem_req_wdata_i = wdata;
    #1;
    check("issue_ready", {31'd0, mem_ready_o}, 32'd1);
    check("issue_exc", {31'd0, mem_resp_exc_o}, {31'd0, exp_exc});
    check("issue_exccode", {26'd0, mem_resp_exccode_o}, {26'd0, exp_code});
    if (be != 4'd0) begin
      cur_id = id;
      cur_we = we;
    end
    cycle();
    mem_valid_i = 1'b0;
  endtask

  task automatic grant_after(input int unsigned wait_cycles, input logic [31:0] addr,
                             input logic we, input logic [3:0] be, input logic [31:0] wdata);
    for (int unsigned i = 0; i <= wait_cycles; i++) begin
      data_gnt_i = (i == wait_cycles);
      #1;
      check("req_held", {31'd0, data_req_o}, 32'd1);
      check("req_addr", data_addr_o, addr);
      check("req_we", {31'd0, data_we_o}, {31'd0, we});
      check("req_be", {28'd0, data_be_o}, {28'd0, be});
      check("req_wdata", data_wdata_o, wdata);
      cycle();
    end
    data_gnt_i = 1'b0;
    #1;
    check("req_dropped_after_gnt", {31'd0, data_req_o}, 32'd0);
  endtask

  task automatic respond(input logic [31:0] rdata, input logic err);
    data_rvalid_i = 1'b1; data_rdata_i = rdata; data_err_i = err;
    cycle();
    data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'd3, 32'h100, 1'b0, 4'hF, 32'h0,        0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
    vecs[1] = '{4'd1, 32'h200, 1'b1, 4'h0, 32'h12345678, 0, 32'h0,        1'b0, 1'b1, 6'd7};
    vecs[2] = '{4'd2, 32'h204, 1'b0, 4'h0, 32'h0,        0, 32'h0,        1'b0, 1'b1, 6'd5};
    vecs[3] = '{4'd7, 32'h300, 1'b1, 4'h3, 32'hA5A5A5A5, 5, 32'hFFFFFFFF, 1'b0, 1'b0, 6'd0};
    vecs[4] = '{4'd9, 32'h404, 1'b0, 4'h4, 32'h0,        2, 32'h0BADF00D, 1'b1, 1'b0, 6'd0};
    vecs[5] = '{4'd9, 32'h408, 1'b0, 4'h8, 32'h0,        1, 32'h11223344, 1'b0, 1'b0, 6'd0};
    cur_id = '0;
    cur_we = 1'b0;

    do_reset();

    foreach (vecs[k]) begin
      issue(vecs[k].id, vecs[k].addr, vecs[k].we, vecs[k].be, vecs[k].wdata,
            vecs[k].exp_exc, vecs[k].exp_code);
      if (vecs[k].be == 4'd0) begin
        #1;
        check("fault_no_req", {31'd0, data_req_o}, 32'd0);
        cycle();
        check("fault_no_req_later", {31'd0, data_req_o}, 32'd0);
        check("fault_ready", {31'd0, mem_ready_o}, 32'd1);
      end else begin
        grant_after(vecs[k].gnt_wait, vecs[k].addr, vecs[k].we, vecs[k].be, vecs[k].wdata);
        cycle();
        respond(vecs[k].rdata, vecs[k].err);
        cycle();
        cycle();
      end
    end

    // Back-pressure at MAX_OUTSTANDING.
    issue(4'd4, 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 6'd0);
    grant_after(0, 32'h10, 1'b0, 4'hF, 32'h0);
    check("ready_count1", {31'd0, mem_ready_o}, 32'd1);
    issue(4'd5, 32'h14, 1'b0, 4'hF, 32'h0, 1'b0, 6'd0);
    grant_after(0, 32'h14, 1'b0, 4'hF, 32'h0);
    check("ready_full", {31'd0, mem_ready_o}, 32'd0);
    mem_valid_i = 1'b1; mem_req_id_i = 4'd6; mem_req_addr_i = 32'h18; mem_req_be_i = 4'hF;
    cycle();
    cycle();
    check("full_no_req", {31'd0, data_req_o}, 32'd0);
    check("full_ready_held_low", {31'd0, mem_ready_o}, 32'd0);
    mem_valid_i = 1'b0;
    respond(32'hAAAA0004, 1'b0);
    check("ready_after_pop", {31'd0, mem_ready_o}, 32'd1);
    issue(4'd6, 32'h18, 1'b0, 4'hF, 32'h0, 1'b0, 6'd0);
    grant_after(0, 32'h18, 1'b0, 4'hF, 32'h0);
    respond(32'hAAAA0005, 1'b0);
    respond(32'hAAAA0006, 1'b1);
    cycle();
    cycle();

    // Reset with two transactions in flight; late responses must vanish.
    issue(4'd10, 32'h20, 1'b0, 4'hF, 32'h0, 1'b0, 6'd0);
    grant_after(0, 32'h20, 1'b0, 4'hF, 32'h0);
    issue(4'd11, 32'h24, 1'b0, 4'hF, 32'h0, 1'b0, 6'd0);
    grant_after(0, 32'h24, 1'b0, 4'hF, 32'h0);
    do_reset();
    respond(32'h55550001, 1'b0);
    respond(32'h55550002, 1'b0);
    cycle();
    cycle();
    check("rst_flush_ready", {31'd0, mem_ready_o}, 32'd1);
    issue(4'd1, 32'h30, 1'b0, 4'hF, 32'h0, 1'b0, 6'd0);
    grant_after(0, 32'h30, 1'b0, 4'hF, 32'h0);
    check("rst_flush_count_one", {31'd0, mem_ready_o}, 32'd1);
    respond(32'h77770001, 1'b0);
    cycle();

    // Grant and response in the same cycle with one outstanding.
    issue(4'd12, 32'h40, 1'b0, 4'hF, 32'h0, 1'b0, 6'd0);
    grant_after(0, 32'h40, 1'b0, 4'hF, 32'h0);
    issue(4'd13, 32'h44, 1'b0, 4'hF, 32'h0, 1'b0, 6'd0);
    data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h0C0C0C0C;
    cycle();
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    #1;
    check("same_cycle_ready", {31'd0, mem_ready_o}, 32'd1);
    cycle();
    respond(32'h0D0D0D0D, 1'b0);
    cycle();
    cycle();

    check("pending_results", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/xif_mem_responder.md
XIF_MEM_RESPONDER -- requirements
Module: xif_mem_responder

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, max granted-but-unanswered OBI transactions (1..8).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port mem_valid_i  input  1  coprocessor memory request valid.
REQ-005 SHALL have port mem_ready_o  output  1  request accepted (handshake = valid & ready).
REQ-006 SHALL have port mem_req_id_i  input  X_ID_WIDTH  instruction ID of request.
REQ-007 SHALL have port mem_req_addr_i  input  32  byte address.
REQ-008 SHALL have port mem_req_we_i  input  1  1 = store, 0 = load.
REQ-009 SHALL have port mem_req_be_i  input  4  byte enables.
REQ-010 SHALL have port mem_req_wdata_i  input  32  store data.
REQ-011 SHALL have port mem_resp_exc_o  output  1  request rejected; valid only in handshake cycle.
REQ-012 SHALL have port mem_resp_exccode_o  output  6  exception code; valid only in handshake cycle.
REQ-013 SHALL have ports data_req_o, data_we_o (output 1), data_addr_o (output 32), data_be_o (output 4), data_wdata_o (output 32): OBI request channel.
REQ-014 SHALL have ports data_gnt_i, data_rvalid_i, data_err_i (input 1), data_rdata_i (input 32): OBI grant/response.
REQ-015 SHALL have ports mem_result_valid_o (output 1), mem_result_id_o (output X_ID_WIDTH), mem_result_rdata_o (output 32), mem_result_err_o (output 1): memory result; no ready, consumer always accepts.

Function
REQ-016 SHALL implement FSM with states IDLE and REQ.
REQ-017 SHALL assert mem_ready_o only in IDLE with outstanding count < MAX_OUTSTANDING; combinational from state/count only, never from mem_valid_i.
REQ-018 SHALL, on handshake with mem_req_be_i == 0, set mem_resp_exc_o = 1, exccode = 5 (load) or 7 (store), stay IDLE, issue no bus transaction, produce no result.
REQ-019 SHALL, on handshake with nonzero be, set mem_resp_exc_o = 0, exccode = 0, register addr/we/be/wdata/id, go to REQ.
REQ-020 SHALL drive data_req_o = 1 and registered request fields, held stable, throughout REQ.
REQ-021 SHALL, in REQ with data_gnt_i = 1, push the ID into the ID FIFO, increment count, return to IDLE next cycle.
REQ-022 SHALL, on data_rvalid_i with FIFO non-empty, pop FIFO and decrement count; register result so mem_result_valid_o is high exactly one cycle, one cycle after rvalid, with popped ID, data_rdata_i (0 for stores), data_err_i.
REQ-023 SHALL return results in grant order; IDs are opaque, duplicates allowed.
REQ-024 SHALL handle grant and rvalid in the same cycle: push and pop both occur, count unchanged.
REQ-025 SHALL ignore data_rvalid_i while FIFO empty (no result, count stays 0).
REQ-026 SHALL keep count in range 0..MAX_OUTSTANDING; no wrap; FIFO pointers wrap modulo MAX_OUTSTANDING.
REQ-027 SHALL deassert mem_ready_o when count == MAX_OUTSTANDING until a response pops.

Reset
REQ-028 SHALL, with rst_i high at a clock edge, enter IDLE, clear count, FIFO pointers and result register, aborting in-flight work; responses arriving after reset are ignored per REQ-025.
REQ-029 SHALL drive all outputs 0 during and after reset until a new request; mem_ready_o = 1 the first cycle after reset release.

Structure
REQ-030 SHALL take X_ID_WIDTH, the IDLE/REQ state enum, and exccode constants (EXC_LOAD_FAULT = 5, EXC_STORE_FAULT = 7) from xif_copro_pkg.
REQ-031 SHALL instantiate one sub-module xif_mem_id_fifo (depth MAX_OUTSTANDING, width X_ID_WIDTH, push/pop/full/empty); no other hierarchy.

Verification
REQ-032 Load id=3 addr=0x100 be=0xF, gnt same cycle as data_req_o, rvalid 2 cycles later rdata=0xDEADBEEF -> one-cycle result id=3 rdata=0xDEADBEEF err=0.
REQ-033 Store id=1 be=0x0 -> exc=1 exccode=7, data_req_o stays 0, no result; load be=0x0 -> exccode=5.
REQ-034 MAX_OUTSTANDING=2, loads id=4,5,6 with rvalid withheld -> two grants, mem_ready_o low after second; rvalid -> result id=4, third load then accepted.
REQ-035 gnt held low 5 cycles -> data_req_o and addr/be/wdata stable all 5 cycles; gnt cycle 6 -> IDLE next cycle.
REQ-036 rst_i pulsed with 2 outstanding, then 2 rvalids -> no results, count 0, mem_ready_o = 1.
REQ-037 Grant and rvalid same cycle with count=1 -> count stays 1, result carries older ID.
